// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: opcodes, controller states and
// the control-word layout used by the controller, ALU and datapath.
package cpu_pkg;

  typedef enum logic [2:0] {
    HLT = 3'b000,
    SKZ = 3'b001,
    ADD = 3'b010,
    AND = 3'b011,
    XOR = 3'b100,
    LDA = 3'b101,
    STO = 3'b110,
    JMP = 3'b111
  } opcode_e;

  typedef enum logic [3:0] {
    INST_ADDR  = 4'd0,
    INST_FETCH = 4'd1,
    INST_LOAD  = 4'd2,
    IDLE       = 4'd3,
    OP_ADDR    = 4'd4,
    OP_FETCH   = 4'd5,
    ALU_OP     = 4'd6,
    STORE      = 4'd7,
    HALTED     = 4'd8
  } state_e;

  typedef struct packed {
    logic sel;
    logic rd;
    logic ld_ir;
    logic inc_pc;
    logic halt;
    logic ld_pc;
    logic data_e;
    logic ld_ac;
    logic wr;
  } ctrl_t;

  // Opcodes that read an operand from memory and load the accumulator.
  function automatic logic is_aluop(input opcode_e op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == LDA);
  endfunction

endpackage

// File: rtl/cpu_controller_if.sv
// Controller <-> datapath bundle: instruction/flag inputs and control strobes.
interface cpu_controller_if;
  logic [2:0] opcode;
  logic       zero;
  logic       sel;
  logic       rd;
  logic       ld_ir;
  logic       inc_pc;
  logic       halt;
  logic       ld_pc;
  logic       data_e;
  logic       ld_ac;
  logic       wr;
  logic [3:0] state;

  modport master (
    input  opcode, zero,
    output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, state
  );

  modport slave (
    output opcode, zero,
    input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr, state
  );
endinterface

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for the accumulator CPU. One state register;
// control strobes are a combinational Moore decode of state plus opcode/zero.
module cpu_controller
  import cpu_pkg::*;
#(
  parameter bit HALT_STICKY = 1'b1
) (
  input  logic           clk,
  input  logic           rst_n,
  cpu_controller_if.master bus
);

  state_e  state_q;
  state_e  state_d;
  opcode_e op;
  ctrl_t   ctrl;

  assign op = opcode_e'(bus.opcode);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= INST_ADDR;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = INST_ADDR;
    case (state_q)
      INST_ADDR:  state_d = INST_FETCH;
      INST_FETCH: state_d = INST_LOAD;
      INST_LOAD:  state_d = IDLE;
      IDLE:       state_d = OP_ADDR;
      OP_ADDR:    state_d = (op == HLT) ? HALTED : OP_FETCH;
      OP_FETCH:   state_d = ALU_OP;
      ALU_OP:     state_d = STORE;
      STORE:      state_d = INST_ADDR;
      HALTED:     state_d = HALT_STICKY ? HALTED : INST_ADDR;
      default:    state_d = INST_ADDR;
    endcase
  end

  // While reset is held the outputs already show INST_ADDR, so a reset that
  // lands mid-instruction cannot leak a write or accumulator load.
  always_comb begin
    ctrl = '0;
    if (!rst_n) begin
      ctrl.sel = 1'b1;
    end else begin
      case (state_q)
        INST_ADDR: ctrl.sel = 1'b1;
        INST_FETCH: begin
          ctrl.sel = 1'b1;
          ctrl.rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          ctrl.sel   = 1'b1;
          ctrl.rd    = 1'b1;
          ctrl.ld_ir = 1'b1;
        end
        OP_ADDR: begin
          ctrl.inc_pc = 1'b1;
          ctrl.halt   = (op == HLT);
        end
        OP_FETCH: ctrl.rd = is_aluop(op);
        ALU_OP: begin
          ctrl.rd     = is_aluop(op);
          ctrl.ld_ac  = is_aluop(op);
          ctrl.inc_pc = (op == SKZ) && bus.zero;
          ctrl.ld_pc  = (op == JMP);
          ctrl.data_e = (op == STO);
        end
        STORE: begin
          ctrl.rd     = is_aluop(op);
          ctrl.ld_ac  = is_aluop(op);
          ctrl.inc_pc = (op == JMP);
          ctrl.ld_pc  = (op == JMP);
          ctrl.data_e = (op == STO);
          ctrl.wr     = (op == STO);
        end
        HALTED: ctrl.halt = 1'b1;
        default: ctrl = '0;
      endcase
    end
  end

  assign bus.sel    = ctrl.sel;
  assign bus.rd     = ctrl.rd;
  assign bus.ld_ir  = ctrl.ld_ir;
  assign bus.inc_pc = ctrl.inc_pc;
  assign bus.halt   = ctrl.halt;
  assign bus.ld_pc  = ctrl.ld_pc;
  assign bus.data_e = ctrl.data_e;
  assign bus.ld_ac  = ctrl.ld_ac;
  assign bus.wr     = ctrl.wr;
  assign bus.state  = rst_n ? state_q : INST_ADDR;

endmodule

// File: tb/tb_cpu_controller.sv
// Directed bench for cpu_controller: one sticky-halt and one non-sticky instance
// run in lockstep through each instruction class, halt and reset scenarios.
module tb_cpu_controller;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cpu_controller_if bus();
  cpu_controller_if bus2();

  cpu_controller #(.HALT_STICKY(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus));
  cpu_controller #(.HALT_STICKY(1'b0)) dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  int checks = 0;
  int errors = 0;

  // Output vector order: sel rd ld_ir inc_pc halt ld_pc data_e ld_ac wr
  localparam logic [8:0] O_IA    = 9'b100000000;
  localparam logic [8:0] O_IF    = 9'b110000000;
  localparam logic [8:0] O_IL    = 9'b111000000;
  localparam logic [8:0] O_OA    = 9'b000100000;
  localparam logic [8:0] O_OAH   = 9'b000110000;
  localparam logic [8:0] O_HALT  = 9'b000010000;
  localparam logic [8:0] O_NONE  = 9'b000000000;
  localparam logic [8:0] O_RD    = 9'b010000000;
  localparam logic [8:0] O_ALU   = 9'b010000010;
  localparam logic [8:0] O_STO_A = 9'b000000100;
  localparam logic [8:0] O_STO_S = 9'b000000101;
  localparam logic [8:0] O_SKZ_A = 9'b000100000;
  localparam logic [8:0] O_JMP_A = 9'b000001000;
  localparam logic [8:0] O_JMP_S = 9'b000101000;

  function automatic logic [8:0] outs1();
    return {bus.sel, bus.rd, bus.ld_ir, bus.inc_pc, bus.halt,
            bus.ld_pc, bus.data_e, bus.ld_ac, bus.wr};
  endfunction

  function automatic logic [8:0] outs2();
    return {bus2.sel, bus2.rd, bus2.ld_ir, bus2.inc_pc, bus2.halt,
            bus2.ld_pc, bus2.data_e, bus2.ld_ac, bus2.wr};
  endfunction

  task automatic chk(input string tag, input logic [8:0] obs, input logic [8:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic set_op(input logic [2:0] op, input logic z);
    bus.opcode  = op;
    bus.zero    = z;
    bus2.opcode = op;
    bus2.zero   = z;
  endtask

  // Starts at a negedge with both DUTs in INST_ADDR; ends back in INST_ADDR.
  task automatic run_instr(input string tag, input logic [2:0] op, input logic z,
                           input logic [8:0] f, input logic [8:0] a, input logic [8:0] s);
    logic [8:0] expo [8];
    expo[0] = O_IA; expo[1] = O_IF; expo[2] = O_IL; expo[3] = O_IL;
    expo[4] = O_OA; expo[5] = f;    expo[6] = a;    expo[7] = s;
    set_op(op, z);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_state_c%0d", tag, i), {5'b0, bus.state}, 9'(i));
      chk($sformatf("%s_outs_c%0d", tag, i), outs1(), expo[i]);
      chk($sformatf("%s_outs2_c%0d", tag, i), outs2(), expo[i]);
      chk($sformatf("%s_wr_rd_c%0d", tag, i), {8'b0, bus.wr & bus.rd}, 9'b0);
      @(negedge clk);
    end
    chk($sformatf("%s_wrap", tag), {5'b0, bus.state}, {5'b0, INST_ADDR});
    chk($sformatf("%s_wrap_outs", tag), outs1(), O_IA);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    set_op(ADD, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("reset_async_state", {5'b0, bus.state}, 9'd0);
    chk("reset_async_outs", outs1(), O_IA);
    @(negedge clk);
    @(negedge clk);
    chk("reset_state", {5'b0, bus.state}, 9'd0);
    chk("reset_outs", outs1(), O_IA);
    chk("reset_outs2", outs2(), O_IA);
    rst_n = 1'b1;
    chk("post_reset_state", {5'b0, bus.state}, 9'd0);

    run_instr("add",    ADD, 1'b0, O_RD,   O_ALU,   O_ALU);
    run_instr("sto",    STO, 1'b0, O_NONE, O_STO_A, O_STO_S);
    run_instr("skz_z1", SKZ, 1'b1, O_NONE, O_SKZ_A, O_NONE);
    run_instr("skz_z0", SKZ, 1'b0, O_NONE, O_NONE,  O_NONE);
    run_instr("jmp",    JMP, 1'b1, O_NONE, O_JMP_A, O_JMP_S);
    run_instr("and",    AND, 1'b1, O_RD,   O_ALU,   O_ALU);
    run_instr("xor",    XOR, 1'b0, O_RD,   O_ALU,   O_ALU);
    run_instr("sto_z1", STO, 1'b1, O_NONE, O_STO_A, O_STO_S);

    // Reset during ALU_OP of LDA
    set_op(LDA, 1'b0);
    for (int i = 0; i < 6; i++) @(negedge clk);
    chk("lda_alu_state", {5'b0, bus.state}, {5'b0, ALU_OP});
    chk("lda_alu_outs", outs1(), O_ALU);
    rst_n = 1'b0;
    #1;
    chk("lda_rst_ld_ac", {8'b0, bus.ld_ac}, 9'b0);
    chk("lda_rst_outs", outs1(), O_IA);
    @(negedge clk);
    chk("lda_rst_next_state", {5'b0, bus.state}, {5'b0, INST_ADDR});
    chk("lda_rst_next_outs", outs1(), O_IA);
    rst_n = 1'b1;
    run_instr("lda", LDA, 1'b1, O_RD, O_ALU, O_ALU);

    // HLT: sticky instance holds, non-sticky instance restarts
    set_op(HLT, 1'b0);
    for (int i = 0; i < 4; i++) @(negedge clk);
    chk("hlt_opaddr_state", {5'b0, bus.state}, {5'b0, OP_ADDR});
    chk("hlt_opaddr_outs", outs1(), O_OAH);
    @(negedge clk);
    chk("hlt_halted_state", {5'b0, bus.state}, {5'b0, HALTED});
    chk("hlt_halted_outs", outs1(), O_HALT);
    chk("hlt2_halted_state", {5'b0, bus2.state}, {5'b0, HALTED});
    chk("hlt2_halted_outs", outs2(), O_HALT);
    @(negedge clk);
    chk("hlt2_restart_state", {5'b0, bus2.state}, {5'b0, INST_ADDR});
    chk("hlt2_restart_outs", outs2(), O_IA);
    for (int i = 0; i < 22; i++) begin
      chk($sformatf("hlt_hold_state_%0d", i), {5'b0, bus.state}, {5'b0, HALTED});
      chk($sformatf("hlt_hold_outs_%0d", i), outs1(), O_HALT);
      @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("hlt_rst_outs", outs1(), O_IA);
    @(negedge clk);
    chk("hlt_rst_state", {5'b0, bus.state}, {5'b0, INST_ADDR});
    chk("hlt_rst_halt", {8'b0, bus.halt}, 9'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("hlt_refetch_state", {5'b0, bus.state}, {5'b0, INST_FETCH});
    chk("hlt_refetch_outs", outs1(), O_IF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 SHALL have parameter HALT_STICKY, default 1: 1 = remain halted after HLT until reset; 0 = return to INST_ADDR after one HALTED cycle.
REQ-002 SHALL have port clk, input, 1, single rising-edge clock.
REQ-003 SHALL have port rst_n, input, 1, reset; reset is synchronous and active-low.
REQ-004 SHALL have port opcode, input, 3, instruction opcode from the instruction register.
REQ-005 SHALL have port zero, input, 1, ALU is_zero flag (accumulator == 0).
REQ-006 SHALL have port sel, output, 1, address mux select: 1 = PC, 0 = IR operand address.
REQ-007 SHALL have port rd, output, 1, memory read enable.
REQ-008 SHALL have port ld_ir, output, 1, instruction register load.
REQ-009 SHALL have port inc_pc, output, 1, program counter increment.
REQ-010 SHALL have port halt, output, 1, processor halted indication.
REQ-011 SHALL have port ld_pc, output, 1, program counter load (jump).
REQ-012 SHALL have port data_e, output, 1, accumulator-to-bus drive enable.
REQ-013 SHALL have port ld_ac, output, 1, accumulator load from ALU result.
REQ-014 SHALL have port wr, output, 1, memory write enable.
REQ-015 SHALL have port state, output, 4, current state encoding, for debug.

Function
REQ-016 SHALL sequence nine states: INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE, HALTED.
REQ-017 SHALL advance one state per clk: INST_ADDR->INST_FETCH->INST_LOAD->IDLE->OP_ADDR->OP_FETCH->ALU_OP->STORE->INST_ADDR.
REQ-018 SHALL go from OP_ADDR to HALTED, not OP_FETCH, when opcode==HLT (000).
REQ-019 SHALL hold HALTED while HALT_STICKY=1; SHALL go HALTED->INST_ADDR when HALT_STICKY=0.
REQ-020 SHALL drive all outputs as Moore decode of state plus the opcode/zero inputs in that state; no output is registered.
REQ-021 SHALL define ALUOP = opcode in {ADD 010, AND 011, XOR 100, LDA 101}.
REQ-022 SHALL assert in INST_ADDR: sel.
REQ-023 SHALL assert in INST_FETCH: sel, rd.
REQ-024 SHALL assert in INST_LOAD and in IDLE: sel, rd, ld_ir.
REQ-025 SHALL assert in OP_ADDR: inc_pc; halt if opcode==HLT.
REQ-026 SHALL assert in OP_FETCH: rd if ALUOP.
REQ-027 SHALL assert in ALU_OP: rd and ld_ac if ALUOP; inc_pc if opcode==SKZ (001) and zero==1; ld_pc if JMP (111); data_e if STO (110).
REQ-028 SHALL assert in STORE: rd and ld_ac if ALUOP; inc_pc and ld_pc if JMP; data_e and wr if STO.
REQ-029 SHALL assert in HALTED: halt only.
REQ-030 SHALL deassert every output in any state and condition not listed in REQ-022..REQ-029.
REQ-031 SHALL give a fixed 8-cycle latency per non-HLT instruction, from INST_ADDR to the next INST_ADDR.
REQ-032 SHALL treat SKZ with zero==0 as a no-op instruction of the same 8 cycles.
REQ-033 SHALL never assert wr and rd in the same cycle.
REQ-034 SHALL never assert ld_pc without inc_pc being legal for that cycle; the PC block gives ld_pc priority.
REQ-035 SHALL map any unreachable state encoding to INST_ADDR on the next clk, with all outputs 0 in that cycle.

Reset
REQ-036 SHALL, on a clk edge with rst_n==0, enter INST_ADDR regardless of current state, including mid-instruction and HALTED.
REQ-037 SHALL, while rst_n==0, drive sel=1 and all other outputs 0, with state = INST_ADDR encoding 0.
REQ-038 SHALL start INST_FETCH on the first clk edge after rst_n returns to 1.

Structure
REQ-039 SHALL take opcode constants (HLT..JMP) and the state enum from shared package cpu_pkg, which the ALU and datapath also import.
REQ-040 SHALL be a single module with no sub-module: one state register and one combinational next-state/output decode.

Verification
REQ-041 SHALL verify ADD (010): reset, then 8 clocks -> rd high in INST_FETCH..IDLE, rd and ld_ac high in ALU_OP and STORE, wr never high, back at INST_ADDR at cycle 8.
REQ-042 SHALL verify STO (110): -> data_e high in ALU_OP and STORE, wr high only in STORE, rd low in OP_FETCH..STORE.
REQ-043 SHALL verify SKZ (001) with zero=1 -> inc_pc pulses in OP_ADDR and ALU_OP (2 total); with zero=0 -> 1 pulse only.
REQ-044 SHALL verify JMP (111): -> ld_pc high in ALU_OP and STORE, inc_pc high in OP_ADDR and STORE.
REQ-045 SHALL verify HLT (000): with HALT_STICKY=1 -> halt high from OP_ADDR and held 20+ cycles; rst_n=0 for one clk -> INST_ADDR, halt=0.
REQ-046 SHALL verify reset mid-instruction: rst_n=0 during ALU_OP of LDA -> next state INST_ADDR, ld_ac=0 that cycle, then normal fetch.
